// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture engine.
package la_pkg;

  // Top-level capture state, shared between the engine and anything observing it.
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDump
  } la_state_e;

  // Sub-phase while streaming the buffer out over the UART.
  typedef enum logic [1:0] {
    DphHeader,
    DphRead,
    DphLoad,
    DphSend
  } la_dump_ph_e;

  localparam logic [7:0] LA_HEADER = 8'hA5;

  // Bytes needed to carry one sample of the given channel count.
  function automatic int unsigned la_bytes_per_sample(input int unsigned channels);
    return (channels + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/la_capture_if.sv
// Byte stream towards uart_tx: data, one-cycle strobe, and the transmitter busy flag.
interface la_capture_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_busy
  );
endinterface

// File: rtl/la_sample_ram.sv
// Sample buffer: one write port, one registered read port, shaped to map onto iCE40 BRAM.
module la_sample_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can infer block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/la_capture.sv
// Logic-analyzer capture engine: prescaled sampling, masked trigger, DEPTH-sample capture,
// then a byte stream (0xA5 header, samples LSB-first) to uart_tx.
// Optional macro LA_EDGE_TRIG_EN adds per-channel edge qualification of the trigger.
module la_capture import la_pkg::*; #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CHANNELS-1:0]   probe_i,
  input  logic                  arm_i,
  input  logic [CHANNELS-1:0]   trig_mask_i,
  input  logic [CHANNELS-1:0]   trig_value_i,
`ifdef LA_EDGE_TRIG_EN
  input  logic [CHANNELS-1:0]   trig_edge_i,
`endif
  input  logic [PRESCALE_W-1:0] prescale_i,
  la_capture_if.master          tx,
  output logic                  armed_o,
  output logic                  capturing_o,
  output logic                  dumping_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB = la_bytes_per_sample(CHANNELS);
  localparam int unsigned SW = NB * 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LastByte = BW'(NB - 1);

  la_state_e             state_q, state_d;
  la_dump_ph_e           dph_q, dph_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [SW-1:0]         shreg_q, shreg_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;

  logic                  running, strobe, trig_hit, send_ok, ram_we;
  logic [CHANNELS-1:0]   ram_rdata, lvl_miss;

  assign running  = (state_q == StArmed) || (state_q == StCapture);
  assign strobe   = running && (div_q == prescale_i);
  // The previous strobe-cycle's pulse blocks a new one while uart_tx raises busy.
  assign send_ok  = !tx.tx_busy && !tx_valid_q;
  assign lvl_miss = (probe_i ^ trig_value_i) & trig_mask_i;

`ifdef LA_EDGE_TRIG_EN
  logic [CHANNELS-1:0] prev_q, changed, edge_miss;
  logic                first_q;

  // Previous ARMED sample; first_q suppresses edge matches on the first strobe after arming.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      first_q <= 1'b1;
    end else if (state_q == StIdle) begin
      first_q <= 1'b1;
    end else if (state_q == StArmed && strobe) begin
      prev_q  <= probe_i;
      first_q <= 1'b0;
    end
  end

  assign changed   = first_q ? '0 : (probe_i ^ prev_q);
  assign edge_miss = trig_mask_i & trig_edge_i & ~changed;
  assign trig_hit  = ~|(lvl_miss | edge_miss);
`else
  assign trig_hit  = ~|lvl_miss;
`endif

  la_sample_ram #(
    .WIDTH (CHANNELS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (probe_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      dph_q      <= DphHeader;
      div_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dph_q      <= dph_d;
      div_q      <= div_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Next-state logic: divider, capture sequencing and the dump byte engine.
  always_comb begin
    state_d    = state_q;
    dph_d      = dph_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_d     = byte_q;
    shreg_d    = shreg_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    ram_we     = 1'b0;
    div_d      = '0;
    if (running) div_d = strobe ? '0 : div_q + PRESCALE_W'(1);

    unique case (state_q)
      StIdle: begin
        wr_ptr_d = '0;
        if (arm_i) state_d = StArmed;
      end
      StArmed: begin
        if (strobe && trig_hit) begin
          ram_we   = 1'b1;
          wr_ptr_d = AW'(1);
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (strobe) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == LastAddr) begin
            state_d  = StDump;
            rd_ptr_d = '0;
            dph_d    = DphHeader;
          end
        end
      end
      StDump: begin
        unique case (dph_q)
          DphHeader: begin
            if (send_ok) begin
              tx_valid_d = 1'b1;
              tx_data_d  = LA_HEADER;
              dph_d      = DphRead;
            end
          end
          // RAM read of rd_ptr_q is in flight this cycle.
          DphRead: dph_d = DphLoad;
          DphLoad: begin
            shreg_d = SW'(ram_rdata);
            byte_d  = '0;
            dph_d   = DphSend;
          end
          DphSend: begin
            if (send_ok) begin
              tx_valid_d = 1'b1;
              tx_data_d  = shreg_q[7:0];
              shreg_d    = shreg_q >> 8;
              byte_d     = byte_q + BW'(1);
              if (byte_q == LastByte) begin
                if (rd_ptr_q == LastAddr) begin
                  state_d = StIdle;
                  dph_d   = DphHeader;
                end else begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
                  dph_d    = DphRead;
                end
              end
            end
          end
          default: dph_d = DphHeader;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  assign armed_o          = (state_q == StArmed);
  assign capturing_o      = (state_q == StCapture);
  assign dumping_o        = (state_q == StDump);
  assign tx.tx_data       = tx_data_q;
  assign tx.tx_data_valid = tx_valid_q;

endmodule

// File: tb/tb_la_capture.sv
// Bench for la_capture: an 8-channel/4-deep and a 12-channel/2-deep instance, a small
// uart_tx busy model, and byte scoreboards fed from a bench-side capture model.
`timescale 1ns/1ps
module tb_la_capture;
  import la_pkg::*;

  localparam int unsigned PW = 16;
  localparam int unsigned BusyLen = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 8-channel, 4-deep instance ----------------
  logic [7:0]    probe8 = '0, mask8 = '0, value8 = '0;
  logic          arm8 = 1'b0;
  logic [PW-1:0] pre8 = '0;
  logic          armed8, cap8, dump8;
  logic          force_busy8 = 1'b0;
  int            busy8_cnt = 0;
  la_capture_if  if8 ();

  la_capture #(.CHANNELS(8), .DEPTH(4), .PRESCALE_W(PW)) u_dut8 (
    .clk_i        (clk),
    .rst_i        (rst),
    .probe_i      (probe8),
    .arm_i        (arm8),
    .trig_mask_i  (mask8),
    .trig_value_i (value8),
`ifdef LA_EDGE_TRIG_EN
    .trig_edge_i  (8'h00),
`endif
    .prescale_i   (pre8),
    .tx           (if8),
    .armed_o      (armed8),
    .capturing_o  (cap8),
    .dumping_o    (dump8)
  );

  // uart_tx model: busy rises one clock after the strobe and stays up BusyLen clocks.
  always @(posedge clk) begin
    if (if8.tx_data_valid) busy8_cnt <= BusyLen;
    else if (busy8_cnt != 0) busy8_cnt <= busy8_cnt - 1;
  end
  assign if8.tx_busy = (busy8_cnt != 0) || force_busy8;

  // ---------------- 12-channel, 2-deep instance ----------------
  logic [11:0]   probe12 = '0;
  logic          arm12 = 1'b0;
  logic          armed12, cap12, dump12;
  int            busy12_cnt = 0;
  la_capture_if  if12 ();

  la_capture #(.CHANNELS(12), .DEPTH(2), .PRESCALE_W(PW)) u_dut12 (
    .clk_i        (clk),
    .rst_i        (rst),
    .probe_i      (probe12),
    .arm_i        (arm12),
    .trig_mask_i  (12'h000),
    .trig_value_i (12'h000),
`ifdef LA_EDGE_TRIG_EN
    .trig_edge_i  (12'h000),
`endif
    .prescale_i   (16'd0),
    .tx           (if12),
    .armed_o      (armed12),
    .capturing_o  (cap12),
    .dumping_o    (dump12)
  );

  always @(posedge clk) begin
    if (if12.tx_data_valid) busy12_cnt <= BusyLen;
    else if (busy12_cnt != 0) busy12_cnt <= busy12_cnt - 1;
  end
  assign if12.tx_busy = (busy12_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0] q8[$];
  logic [7:0] q12[$];
  logic       prev_v8 = 1'b0, prev_v12 = 1'b0;
  int         pulses8 = 0;

  always @(negedge clk) begin
    if (if8.tx_data_valid) begin
      pulses8++;
      chk("back_to_back8", {31'd0, prev_v8}, 32'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte8: got 0x%0h, expected no byte", if8.tx_data);
      end else begin
        chk("byte8", {24'd0, if8.tx_data}, {24'd0, q8.pop_front()});
      end
    end
    prev_v8 = if8.tx_data_valid;
  end

  always @(negedge clk) begin
    if (if12.tx_data_valid) begin
      chk("back_to_back12", {31'd0, prev_v12}, 32'd0);
      if (q12.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte12: got 0x%0h, expected no byte", if12.tx_data);
      end else begin
        chk("byte12", {24'd0, if12.tx_data}, {24'd0, q12.pop_front()});
      end
    end
    prev_v12 = if12.tx_data_valid;
  end

  // ---------------- vector table for the 8-channel instance ----------------
  // probe at cycle k (k=0 is the arm cycle) = base + inc*k, OR'd with set once k > hold.
  typedef struct {
    logic [PW-1:0] pre;
    logic [7:0]    mask;
    logic [7:0]    value;
    logic [7:0]    base;
    logic [7:0]    inc;
    logic [7:0]    set;
    int            hold;
    bit            hold_busy;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int pre, input int mask, input int value, input int base,
                              input int inc, input int set, input int hold, input bit hb);
    vec_t v;
    v.pre = PW'(pre);
    v.mask = 8'(mask);
    v.value = 8'(value);
    v.base = 8'(base);
    v.inc = 8'(inc);
    v.set = 8'(set);
    v.hold = hold;
    v.hold_busy = hb;
    return v;
  endfunction

  function automatic logic [7:0] probe_at(input vec_t v, input int k);
    int t;
    t = int'(v.base) + int'(v.inc) * k;
    if (k > v.hold) t = t | int'(v.set);
    return 8'(t);
  endfunction

  task automatic run8(input vec_t v, input int idx);
    int trig_k = -1, last_k = -1, n = 0;
    int cap_k = -1, dump_k = -1;
    int hold_left = 0, rel_left = 0, pb = 0;
    bit done = 1'b0;
    logic [7:0] p;
    // Bench model of strobe timing and trigger: strobes fall on k = (pre+1)*j.
    q8.push_back(LA_HEADER);
    for (int k = 1; k < 5000 && last_k < 0; k++) begin
      if (k % (int'(v.pre) + 1) == 0) begin
        p = probe_at(v, k);
        if (trig_k < 0) begin
          if ((p & v.mask) == (v.value & v.mask)) begin
            trig_k = k;
            q8.push_back(p);
            n = 1;
          end
        end else begin
          q8.push_back(p);
          n++;
        end
        if (trig_k >= 0 && n == 4) last_k = k;
      end
    end

    @(posedge clk); #1;
    pre8 = v.pre;
    mask8 = v.mask;
    value8 = v.value;
    arm8 = 1'b1;
    probe8 = probe_at(v, 0);
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk($sformatf("armed_v%0d", idx), {31'd0, armed8}, 32'd1);
      if (cap8 && cap_k < 0) cap_k = k;
      if (dump8 && dump_k < 0) begin
        dump_k = k;
        if (v.hold_busy) begin
          force_busy8 = 1'b1;
          hold_left = 100;
          pb = pulses8;
        end
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          chk("pulses_while_busy", pulses8 - pb, 0);
          force_busy8 = 1'b0;
          pb = pulses8;
          rel_left = 3;
        end
      end else if (rel_left > 0) begin
        rel_left--;
        if (rel_left == 0) chk("pulses_after_release", pulses8 - pb, 1);
      end
      if (dump_k >= 0 && !dump8 && !armed8 && !cap8) done = 1'b1;
      arm8 = 1'b0;
      probe8 = probe_at(v, k + 1);
    end
    @(negedge clk); #1;
    chk($sformatf("finished_v%0d", idx), {31'd0, done}, 32'd1);
    chk($sformatf("capture_start_v%0d", idx), cap_k, trig_k);
    chk($sformatf("dump_start_v%0d", idx), dump_k, last_k);
    chk($sformatf("bytes_left_v%0d", idx), q8.size(), 0);
    chk($sformatf("idle_flags_v%0d", idx), {29'd0, armed8, cap8, dump8}, 32'd0);
    q8.delete();
  endtask

  initial begin
    vecs[0] = mk(0, 'h00, 'h00, 'h0F, 1, 'h00, 1000, 1'b0); // A5 10 11 12 13
    vecs[1] = mk(0, 'h01, 'h01, 'h40, 2, 'h01, 20, 1'b0);   // bit0 rises at k=21
    vecs[2] = mk(3, 'h00, 'h00, 'h00, 1, 'h00, 1000, 1'b0); // samples at k=4,8,12,16
    vecs[3] = mk(1, 'hF0, 'h30, 'h00, 1, 'h00, 1000, 1'b0); // trigger at k=0x30
    vecs[4] = mk(0, 'h00, 'h00, 'h20, 1, 'h00, 1000, 1'b1); // tx_busy held 100 clocks
    vecs[5] = mk(2, 'h81, 'h80, 'h7C, 1, 'h00, 1000, 1'b0); // trigger at k=6 (0x82)

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags8", {28'd0, armed8, cap8, dump8, if8.tx_data_valid}, 32'd0);
    chk("reset_txdata8", {24'd0, if8.tx_data}, 32'd0);
    chk("reset_flags12", {29'd0, armed12, cap12, dump12}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run8(vecs[i], i);

    // arm while not IDLE is ignored: pulse arm during CAPTURE must not disturb the stream.
    begin
      int cnt = 0;
      q8.push_back(LA_HEADER);
      for (int i = 0; i < 4; i++) q8.push_back(8'h3C);
      @(posedge clk); #1;
      pre8 = '0; mask8 = '0; probe8 = 8'h3C; arm8 = 1'b1;
      @(posedge clk); #1;
      arm8 = 1'b0;
      @(posedge clk); #1;
      arm8 = 1'b1;
      @(posedge clk); #1;
      arm8 = 1'b0;
      while (cnt < 500 && (armed8 || cap8 || dump8)) begin
        @(posedge clk); #1;
        cnt++;
      end
      @(negedge clk); #1;
      chk("rearm_ignored_left", q8.size(), 0);
      chk("rearm_ignored_idle", {29'd0, armed8, cap8, dump8}, 32'd0);
      q8.delete();
    end

    // 12 channels, 2 deep: two bytes per sample, LSB first, high nibble zero-padded.
    begin
      int cnt = 0;
      bit seen = 1'b0;
      q12.push_back(LA_HEADER);
      q12.push_back(8'hBC);
      q12.push_back(8'h0A);
      q12.push_back(8'hBC);
      q12.push_back(8'h0A);
      @(posedge clk); #1;
      probe12 = 12'hABC;
      arm12 = 1'b1;
      @(posedge clk); #1;
      arm12 = 1'b0;
      while (cnt < 500 && !(seen && !dump12)) begin
        @(posedge clk); #1;
        if (dump12) seen = 1'b1;
        cnt++;
      end
      @(negedge clk); #1;
      chk("ch12_dumped", {31'd0, seen}, 32'd1);
      chk("ch12_bytes_left", q12.size(), 0);
      chk("ch12_idle", {29'd0, armed12, cap12, dump12}, 32'd0);
    end

    // Reset in the middle of a dump, then a fresh complete capture.
    begin
      int cnt = 0;
      int p0;
      q8.push_back(LA_HEADER);
      for (int i = 0; i < 4; i++) q8.push_back(8'h55);
      @(posedge clk); #1;
      pre8 = '0; mask8 = '0; probe8 = 8'h55; arm8 = 1'b1;
      p0 = pulses8;
      @(posedge clk); #1;
      arm8 = 1'b0;
      while (cnt < 500 && pulses8 < p0 + 2) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("mid_dump_reached", {31'd0, dump8}, 32'd1);
      @(posedge clk); #6;
      rst = 1'b1;
      #1;
      chk("rst_mid_dump_flags", {28'd0, armed8, cap8, dump8, if8.tx_data_valid}, 32'd0);
      chk("rst_mid_dump_txdata", {24'd0, if8.tx_data}, 32'd0);
      q8.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      run8(vecs[0], 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_capture.md
Name: la_capture

Overview:
- Parametrised logic-analyzer capture engine for the iCEstick.
- Samples CHANNELS probe inputs at a programmable prescaled rate and arms on command.
- Waits for a masked level trigger, fills a DEPTH-entry sample buffer, then streams the buffer as bytes to the existing uart_tx block.
- Sits between the PMOD probe pins and uart_tx in the top level.

Parameters:
- CHANNELS, 8, number of probe inputs (1..32).
- DEPTH, 256, samples stored per capture (power of two, >=2).
- PRESCALE_W, 16, width of sample-rate divider.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- probe  in  CHANNELS  probe inputs, already synchronised externally
- arm  in  1  one-cycle pulse; start a capture
- trig_mask  in  CHANNELS  1 = channel participates in trigger
- trig_value  in  CHANNELS  required level per masked channel
- prescale  in  PRESCALE_W  sample every prescale+1 clocks
- tx_busy  in  1  uart_tx transmitting flag
- tx_data  out  8  byte to uart_tx
- tx_data_valid  out  1  one-cycle byte strobe
- armed  out  1  high in ARMED
- capturing  out  1  high in CAPTURE
- dumping  out  1  high in DUMP

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0; counters 0.
  - Buffer contents undefined.
- Sample strobe:
  - Divider counts 0..prescale; strobe when it equals prescale, then wraps to 0.
  - Divider runs only in ARMED/CAPTURE and is cleared on entry to ARMED.
  - prescale=0 gives a strobe every clock.
- State machine, encoded as a shared enum:
  - IDLE: arm -> ARMED. arm in any other state is ignored.
  - ARMED: on a strobe where (probe & trig_mask) == (trig_value & trig_mask), write that sample to address 0 and go to CAPTURE with wr_ptr=1.
    - trig_mask=0 triggers on the first strobe.
  - CAPTURE: each strobe writes probe to buffer[wr_ptr] and increments wr_ptr. After the write at address DEPTH-1, go to DUMP with rd_ptr=0.
  - DUMP: emits header byte 0xA5, then for each sample rd_ptr=0..DEPTH-1 emits NB=ceil(CHANNELS/8) bytes, least-significant byte first. Unused high bits are zero. After the last byte, go to IDLE.
- UART handshake:
  - tx_data_valid pulses for exactly 1 cycle, only when tx_busy=0.
  - Pulses are never issued on consecutive cycles: a 1-cycle guard covers uart_tx raising transmitting one clock after valid.
  - tx_data is stable during the pulse and holds its value afterwards.
- Buffer read:
  - Synchronous, 1-cycle latency.
  - The engine issues the read address, waits 1 cycle, then loads the byte shift register before qualifying valid.
- Pointers:
  - log2(DEPTH) bits wide. Wrap from DEPTH-1 to 0 is the completion condition and is never taken as a fault.
- Reset mid-capture or mid-dump: return to IDLE at once.
  - A byte already handed to uart_tx completes in uart_tx and is not repeated.
- Probe changes between strobes are not recorded (no glitch capture).

Optional Feature:
- Macro: LA_EDGE_TRIG_EN.
- Defined:
  - Adds input trig_edge [CHANNELS].
  - A masked channel with trig_edge=1 matches only when its value differs from the previous strobe's sample and now equals trig_value, i.e. a rising or falling edge.
  - Previous-sample register resets to 0 and is loaded on every strobe in ARMED.
  - The first strobe after arming cannot produce an edge match.
- Undefined:
  - Level trigger only; port absent.

Decomposition:
- Package la_pkg:
  - state enum (IDLE, ARMED, CAPTURE, DUMP).
  - LA_HEADER=8'hA5.
  - Function computing bytes per sample from CHANNELS.
- Sub-module la_sample_ram: single-port-write/single-port-read synchronous RAM, DEPTH x CHANNELS, inferring iCE40 BRAM.

Test Plan:
- CHANNELS=8, DEPTH=4, prescale=0, mask=0, probe counting 0x10,0x11,… each clock, arm -> bytes A5,10,11,12,13; DUMP then IDLE.
- mask=0x01, value=0x01, probe bit0 low for 20 clocks then high -> capturing asserts on the first strobe after bit0 rises; first data byte has bit0=1.
- CHANNELS=12, DEPTH=2, probe=0xABC constant -> bytes A5,BC,0A,BC,0A.
- prescale=3, DEPTH=4, mask=0 -> capture spans 16 clocks from arm; samples taken every 4th clock.
- tx_busy held high for 100 clocks during DUMP -> no valid pulses. After release, exactly one pulse; no back-to-back pulses ever.
- rst asserted mid-DUMP -> outputs 0 within the same cycle, state IDLE. A new arm then produces a complete fresh stream starting with A5.
